// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with in-order prefetch FIFO and redirect flush; optional IF_MISALIGN_CHECK_EN
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGnt,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  input  logic        imemErr,
  input  logic        jumpFlag,
  input  logic [31:0] jumpAddr,
  input  logic        holdFlag,
  output logic [31:0] pcAddr,
  output logic [31:0] instr,
  output logic        instrValid,
  output logic        instrErr
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic        misalignFlag
`endif
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = AW + 2;
  localparam logic [LW-1:0] DEPTH = LW'(BUF_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic          run;
  logic          halted;
  logic          pop;
  logic          push;
  logic          grant;
  logic          drop;
  logic [LW-1:0] load;
  logic [31:0]   jump_pc;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] cnt;
  logic [7:0]    drop_cnt;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   pc_q   [BUF_DEPTH];
  logic [31:0]   word_q [BUF_DEPTH];
  logic          err_q  [BUF_DEPTH];
  assign jump_pc    = jumpAddr & 32'hFFFF_FFFC;
  assign imemAddr   = fetch_pc;
  assign instrValid = cnt != '0;
  assign instrErr   = instrValid && err_q[rd_ptr];
  assign instr      = instrValid ? word_q[rd_ptr] : NOP;
  assign pcAddr     = instrValid ? pc_q[rd_ptr] : resp_pc;
`ifdef IF_MISALIGN_CHECK_EN
  logic mis;
  // A misaligned redirect parks issue until the next aligned redirect
  always_ff @(posedge clk or negedge rst)
    if (!rst) mis <= 1'b0;
    else if (jumpFlag) mis <= |jumpAddr[1:0];
  assign halted       = mis;
  assign misalignFlag = mis;
`else
  assign halted = 1'b0;
`endif
  // Issue only while granted-but-unanswered plus buffered words still fit the FIFO
  always_comb begin
    pop     = instrValid && !holdFlag && !jumpFlag;
    load    = LW'(out_cnt) + LW'(cnt) - LW'(pop);
    imemReq = run && !halted && !jumpFlag && load < DEPTH;
    grant   = imemReq && imemGnt;
    drop    = drop_cnt != '0;
    push    = imemRvalid && !drop && !jumpFlag;
  end
  // Fetch/response PCs, in-flight and discard counters, FIFO pointers; redirect wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run      <= 1'b0;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
      cnt      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      run <= 1'b1;
      if (jumpFlag) begin
        fetch_pc <= jump_pc;
        resp_pc  <= jump_pc;
        out_cnt  <= '0;
        drop_cnt <= drop_cnt + 8'(out_cnt) + 8'(grant) - 8'(imemRvalid);
        cnt      <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (push) resp_pc <= resp_pc + 32'd4;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        out_cnt  <= out_cnt + CW'(grant) - CW'(imemRvalid && !drop);
        drop_cnt <= drop_cnt - 8'(imemRvalid && drop);
        cnt      <= cnt + CW'(push) - CW'(pop);
      end
    end
  end
  // FIFO storage; an errored response is stored as a NOP
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]   <= resp_pc;
      word_q[wr_ptr] <= imemErr ? NOP : imemRdata;
      err_q[wr_ptr]  <= imemErr;
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized bench checking if_fetch against a queue-based fetch model
module tb_if_fetch;
  localparam int D = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct { logic [31:0] pc; logic [31:0] w; logic e; } ent_t;
  typedef struct { logic [31:0] pc; bit drop; } fl_t;
  logic clk = 1'b0;
  logic rst;
  logic imemReq, imemGnt, imemRvalid, imemErr, jumpFlag, holdFlag, instrValid, instrErr;
  logic [31:0] imemAddr, imemRdata, jumpAddr, pcAddr, instr;
`ifdef IF_MISALIGN_CHECK_EN
  logic misalignFlag;
  bit m_mis_en = 1'b1;
`endif
  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int gnt_p, rv_p, lat, hold_p, jump_p, err_p;
  bit f_jump, f_hold, seen;
  logic [31:0] f_jaddr, err_addr;
  logic [31:0] m_pc;
  bit m_mis;
  fl_t flight[$];
  ent_t outq[$];
  logic [31:0] mem_a[$];
  int mem_r[$];

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0), .BUF_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt),
    .imemRvalid(imemRvalid), .imemRdata(imemRdata), .imemErr(imemErr),
    .jumpFlag(jumpFlag), .jumpAddr(jumpAddr), .holdFlag(holdFlag),
    .pcAddr(pcAddr), .instr(instr), .instrValid(instrValid), .instrErr(instrErr)
`ifdef IF_MISALIGN_CHECK_EN
    , .misalignFlag(misalignFlag)
`endif
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    a = ($urandom_range(3) == 0) ? (a | 32'hFFFF_FF00) : (a & 32'h0000_0FFF);
    if ($urandom_range(3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    m_mis = 1'b0;
    flight.delete();
    outq.delete();
    mem_a.delete();
    mem_r.delete();
  endtask

  task automatic reset_check();
    chk("rst_imemReq", imemReq, 0);
    chk("rst_imemAddr", imemAddr, 32'h0);
    chk("rst_pcAddr", pcAddr, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_instrValid", instrValid, 0);
    chk("rst_instrErr", instrErr, 0);
`ifdef IF_MISALIGN_CHECK_EN
    chk("rst_misalignFlag", misalignFlag, 0);
`endif
  endtask

  task automatic step();
    int live;
    bit pop, req;
    ent_t h;
    fl_t f;
    @(negedge clk);
    jumpFlag   = f_jump || ($urandom_range(99) < jump_p);
    jumpAddr   = f_jump ? f_jaddr : rnd_addr();
    holdFlag   = f_hold || ($urandom_range(99) < hold_p);
    imemGnt    = $urandom_range(99) < gnt_p;
    imemRvalid = mem_a.size() > 0 && mem_r[0] <= cyc && $urandom_range(99) < rv_p;
    imemRdata  = imemRvalid ? mem_a[0] : $urandom;
    imemErr    = imemRvalid ? (mem_a[0] == err_addr || $urandom_range(99) < err_p) : 1'($urandom_range(1));
    #1;
    live = 0;
    foreach (flight[i]) if (!flight[i].drop) live++;
    pop = outq.size() > 0 && !holdFlag && !jumpFlag;
    req = !jumpFlag && !m_mis && (live + outq.size() - int'(pop)) < D;
    chk("imemReq", imemReq, req);
    if (req) chk("imemAddr", imemAddr, m_pc);
    chk("instrValid", instrValid, outq.size() > 0);
    if (outq.size() > 0) begin
      h = outq[0];
      chk("pcAddr", pcAddr, h.pc);
      chk("instr", instr, h.e ? NOP : h.w);
      chk("instrErr", instrErr, h.e);
    end else begin
      chk("instr_empty", instr, NOP);
      chk("instrErr_empty", instrErr, 0);
    end
`ifdef IF_MISALIGN_CHECK_EN
    chk("misalignFlag", misalignFlag, m_mis);
`endif
    if (imemReq && imemGnt) begin
      mem_a.push_back(imemAddr);
      mem_r.push_back(cyc + 1 + $urandom_range(lat));
    end
    if (jumpFlag) begin
      if (imemRvalid && flight.size() > 0) f = flight.pop_front();
      foreach (flight[i]) flight[i].drop = 1'b1;
      outq.delete();
      m_pc = jumpAddr & 32'hFFFF_FFFC;
`ifdef IF_MISALIGN_CHECK_EN
      m_mis = m_mis_en && jumpAddr[1:0] != 2'b00;
`endif
    end else begin
      if (pop) void'(outq.pop_front());
      if (imemRvalid && flight.size() > 0) begin
        f = flight.pop_front();
        if (!f.drop) begin
          h.pc = f.pc;
          h.w = imemRdata;
          h.e = imemErr;
          outq.push_back(h);
        end
      end
      if (req && imemGnt) begin
        f.pc = m_pc;
        f.drop = 1'b0;
        flight.push_back(f);
        m_pc += 32'd4;
      end
    end
    if (imemRvalid) begin
      void'(mem_a.pop_front());
      void'(mem_r.pop_front());
    end
    cyc++;
  endtask

  initial begin
    rst = 1'b0;
    jumpFlag = 0; jumpAddr = 0; holdFlag = 0; imemGnt = 0; imemRvalid = 0; imemRdata = 0; imemErr = 0;
    gnt_p = 100; rv_p = 100; lat = 0; hold_p = 0; jump_p = 0; err_p = 0;
    f_jump = 0; f_hold = 0; f_jaddr = 0; err_addr = 32'h8;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    reset_check();
    @(negedge clk);
    rst = 1'b1;
    // zero-wait memory, word = address, error on 0x8
    step(); chk("z0_addr", imemAddr, 32'h0); chk("z0_req", imemReq, 1);
    step(); chk("z1_addr", imemAddr, 32'h4); chk("z1_valid", instrValid, 0);
    step(); chk("z2_valid", instrValid, 1); chk("z2_pc", pcAddr, 32'h0); chk("z2_instr", instr, 32'h0);
    step(); chk("z3_pc", pcAddr, 32'h4); chk("z3_instr", instr, 32'h4);
    step(); chk("err_pc", pcAddr, 32'h8); chk("err_flag", instrErr, 1); chk("err_instr", instr, NOP);
    step(); chk("c_pc", pcAddr, 32'hC); chk("c_instr", instr, 32'hC); chk("c_err", instrErr, 0);
    err_addr = 32'h1;
    // decode stall: the FIFO fills and issue stops
    f_hold = 1'b1;
    repeat (5) begin
      step(); chk("hold_req", imemReq, 0); chk("hold_pc", pcAddr, 32'h10);
    end
    f_hold = 1'b0;
    // delayed grant: request and address held steady
    gnt_p = 0;
    step(); chk("dg_addr0", imemAddr, 32'h18); chk("dg_req0", imemReq, 1); chk("dg_pc0", pcAddr, 32'h10);
    step(); chk("dg_addr1", imemAddr, 32'h18); chk("dg_req1", imemReq, 1); chk("dg_pc1", pcAddr, 32'h14);
    step(); chk("dg_addr2", imemAddr, 32'h18); chk("dg_req2", imemReq, 1);
    gnt_p = 100;
    // redirect with two responses in flight
    rv_p = 0;
    repeat (3) step();
    chk("inflight_req", imemReq, 0);
    f_jump = 1'b1; f_jaddr = 32'h100;
    step();
    f_jump = 1'b0; rv_p = 100;
    step(); chk("j1_addr", imemAddr, 32'h100); chk("j1_req", imemReq, 1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (instrValid) begin
        seen = 1'b1;
        chk("jump_first_pc", pcAddr, 32'h100);
      end
    end
    if (!seen) chk("jump_first_timeout", 0, 1);
    // wrap at the top of the address space
    f_jump = 1'b1; f_jaddr = 32'hFFFF_FFF8;
    step();
    f_jump = 1'b0;
    step(); chk("wrap0", imemAddr, 32'hFFFF_FFF8);
    step(); chk("wrap1", imemAddr, 32'hFFFF_FFFC);
    step(); chk("wrap2", imemAddr, 32'h0);
`ifdef IF_MISALIGN_CHECK_EN
    f_jump = 1'b1; f_jaddr = 32'h102;
    step();
    f_jump = 1'b0;
    repeat (3) begin
      step(); chk("mis_flag", misalignFlag, 1); chk("mis_req", imemReq, 0);
    end
    f_jump = 1'b1; f_jaddr = 32'h200;
    step();
    f_jump = 1'b0;
    step(); chk("mis_clear", misalignFlag, 0); chk("mis_addr", imemAddr, 32'h200);
`endif
    // random traffic
    gnt_p = 70; rv_p = 70; lat = 3; hold_p = 20; jump_p = 3; err_p = 5;
    repeat (3000) step();
    // asynchronous reset mid-operation
    @(posedge clk);
    #2;
    rst = 1'b0;
    jumpFlag = 0; holdFlag = 0; imemGnt = 0; imemRvalid = 0; imemErr = 0;
    model_reset();
    #1;
    reset_check();
    @(negedge clk);
    rst = 1'b1;
    repeat (2000) step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
